// File: rtl/lsu_sram_resp_if.sv
// Bundle for the core-side request/response handshake and the 16-bit async SRAM pins.
// The slave modport is the responder; the master modport is the core/board side.
interface lsu_sram_resp_if #(
    parameter int SRAM_AW = 18
);
    logic               i_req;
    logic               i_wren;
    logic [31:0]        i_addr;
    logic [31:0]        i_wdata;
    logic [2:0]         i_num_byte;
    logic [31:0]        o_rdata;
    logic               o_ACK;
    logic               o_err;
    logic [SRAM_AW-1:0] o_SRAM_ADDR;
    logic [15:0]        o_SRAM_DQ;
    logic [15:0]        i_SRAM_DQ;
    logic               o_SRAM_DQ_oe;
    logic               o_SRAM_CE_N;
    logic               o_SRAM_OE_N;
    logic               o_SRAM_WE_N;
    logic               o_SRAM_UB_N;
    logic               o_SRAM_LB_N;

    modport slave (
        input  i_req, i_wren, i_addr, i_wdata, i_num_byte, i_SRAM_DQ,
        output o_rdata, o_ACK, o_err, o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_oe,
               o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N
    );

    modport master (
        output i_req, i_wren, i_addr, i_wdata, i_num_byte, i_SRAM_DQ,
        input  o_rdata, o_ACK, o_err, o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_oe,
               o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N
    );
endinterface

// File: rtl/lsu_sram_resp.sv
// LSU responder driving a 16-bit asynchronous SRAM with multi-cycle half-word phases.
// All pins are registered from the current state, so pin activity trails the FSM by one cycle.
module lsu_sram_resp #(
    parameter int WAIT_CYC = 2,
    parameter int SRAM_AW  = 18
) (
    input  logic            i_clk,
    input  logic            i_rst,
    lsu_sram_resp_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_WR_LO = 3'd3;
    localparam logic [2:0] S_WR_HI = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

    logic [2:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wren_q, wren_d;
    logic [SRAM_AW:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         nb_q, nb_d;
    logic               bad_q, bad_d;
    logic               cap_lo_q, cap_lo_d;
    logic               cap_fin_q, cap_fin_d;
    logic [15:0]        lo_q, lo_d;

    logic [31:0]        rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [SRAM_AW-1:0] saddr_q, saddr_d;
    logic [15:0]        dq_q, dq_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               ub_n_q, ub_n_d;
    logic               lb_n_q, lb_n_d;

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.i_addr[31:SRAM_AW+1];

    logic is_word, is_byte, last, req_bad;
    assign is_word = (nb_q == 3'd4);
    assign is_byte = (nb_q[2:1] == 2'b00);
    assign last    = (cnt_q == LAST_CNT);
    assign req_bad = (bus.i_num_byte > 3'd4)
                  || ((bus.i_num_byte[2:1] == 2'b01) && bus.i_addr[0])
                  || ((bus.i_num_byte == 3'd4) && (bus.i_addr[1:0] != 2'b00));

    function automatic logic [31:0] extend(input logic [2:0] nb, input logic a0,
                                           input logic [15:0] dq, input logic [15:0] lo);
        logic [7:0] b;
        b = a0 ? dq[15:8] : dq[7:0];
        case (nb)
            3'd0:    extend = {{24{b[7]}}, b};
            3'd1:    extend = {24'h0, b};
            3'd2:    extend = {{16{dq[15]}}, dq};
            3'd3:    extend = {16'h0, dq};
            default: extend = {dq, lo};
        endcase
    endfunction

    // Sequencing: phase counter, request latch and read-capture scheduling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wren_d    = wren_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        nb_d      = nb_q;
        bad_d     = bad_q;
        cap_lo_d  = 1'b0;
        cap_fin_d = 1'b0;
        lo_d      = cap_lo_q ? bus.i_SRAM_DQ : lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_req) begin
                    wren_d  = bus.i_wren;
                    addr_d  = bus.i_addr[SRAM_AW:0];
                    wdata_d = bus.i_wdata;
                    nb_d    = bus.i_num_byte;
                    bad_d   = req_bad;
                    cnt_d   = '0;
                    state_d = req_bad ? S_DONE : (bus.i_wren ? S_WR_LO : S_RD_LO);
                end
            end
            S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI: begin
                if (last) begin
                    cnt_d = '0;
                    if ((state_q == S_RD_LO) && is_word) begin
                        state_d  = S_RD_HI;
                        cap_lo_d = 1'b1;
                    end else if ((state_q == S_WR_LO) && is_word) begin
                        state_d  = S_WR_HI;
                    end else begin
                        state_d   = S_DONE;
                        cap_fin_d = !wren_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin and response registers, derived from the current state.
    always_comb begin
        logic rd, wr, act, hi;
        rd  = (state_q == S_RD_LO) || (state_q == S_RD_HI);
        wr  = (state_q == S_WR_LO) || (state_q == S_WR_HI);
        act = rd || wr;
        hi  = (state_q == S_RD_HI) || (state_q == S_WR_HI);

        ce_n_d  = !act;
        oe_n_d  = !rd;
        we_n_d  = !(wr && !last);
        dq_oe_d = wr;
        ub_n_d  = !(act && (!is_byte || addr_q[0]));
        lb_n_d  = !(act && (!is_byte || !addr_q[0]));
        saddr_d = saddr_q;
        if (act) saddr_d = hi ? addr_q[SRAM_AW:1] + SRAM_AW'(1) : addr_q[SRAM_AW:1];
        dq_d = dq_q;
        if (state_q == S_WR_LO) dq_d = is_byte ? {2{wdata_q[7:0]}} : wdata_q[15:0];
        else if (state_q == S_WR_HI) dq_d = wdata_q[31:16];

        ack_d   = (state_q == S_DONE);
        err_d   = (state_q == S_DONE) && bad_q;
        rdata_d = rdata_q;
        if ((state_q == S_DONE) && bad_q) rdata_d = '0;
        else if (cap_fin_q) rdata_d = extend(nb_q, addr_q[0], bus.i_SRAM_DQ, lo_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            nb_q      <= '0;
            bad_q     <= 1'b0;
            cap_lo_q  <= 1'b0;
            cap_fin_q <= 1'b0;
            lo_q      <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            saddr_q   <= '0;
            dq_q      <= '0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            nb_q      <= nb_d;
            bad_q     <= bad_d;
            cap_lo_q  <= cap_lo_d;
            cap_fin_q <= cap_fin_d;
            lo_q      <= lo_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            saddr_q   <= saddr_d;
            dq_q      <= dq_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
        end
    end

    assign bus.o_rdata      = rdata_q;
    assign bus.o_ACK        = ack_q;
    assign bus.o_err        = err_q;
    assign bus.o_SRAM_ADDR  = saddr_q;
    assign bus.o_SRAM_DQ    = dq_q;
    assign bus.o_SRAM_DQ_oe = dq_oe_q;
    assign bus.o_SRAM_CE_N  = ce_n_q;
    assign bus.o_SRAM_OE_N  = oe_n_q;
    assign bus.o_SRAM_WE_N  = we_n_q;
    assign bus.o_SRAM_UB_N  = ub_n_q;
    assign bus.o_SRAM_LB_N  = lb_n_q;
endmodule

// File: tb/tb_lsu_sram_resp.sv
// Directed bench for lsu_sram_resp with a behavioural async SRAM and strobe activity monitors.
module tb_lsu_sram_resp;
    localparam int W  = 2;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_sram_resp_if #(.SRAM_AW(AW)) bus();
    lsu_sram_resp #(.WAIT_CYC(W), .SRAM_AW(AW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    logic [15:0] mem [0:255];
    assign bus.i_SRAM_DQ = (!bus.o_SRAM_CE_N && !bus.o_SRAM_OE_N) ? mem[bus.o_SRAM_ADDR[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!bus.o_SRAM_CE_N && !bus.o_SRAM_WE_N) begin
            if (!bus.o_SRAM_LB_N) mem[bus.o_SRAM_ADDR[7:0]][7:0]  <= bus.o_SRAM_DQ[7:0];
            if (!bus.o_SRAM_UB_N) mem[bus.o_SRAM_ADDR[7:0]][15:8] <= bus.o_SRAM_DQ[15:8];
        end
    end

    int ce_cnt = 0, oe_cnt = 0, we_cnt = 0, ub_cnt = 0, lb_cnt = 0;
    always @(posedge clk) begin
        if (!bus.o_SRAM_CE_N) ce_cnt++;
        if (!bus.o_SRAM_CE_N && !bus.o_SRAM_OE_N) oe_cnt++;
        if (!bus.o_SRAM_CE_N && !bus.o_SRAM_WE_N) we_cnt++;
        if (!bus.o_SRAM_CE_N && !bus.o_SRAM_UB_N) ub_cnt++;
        if (!bus.o_SRAM_CE_N && !bus.o_SRAM_LB_N) lb_cnt++;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int lat;
    int c0, o0, w0, u0, l0;

    task automatic snap();
        c0 = ce_cnt; o0 = oe_cnt; w0 = we_cnt; u0 = ub_cnt; l0 = lb_cnt;
    endtask

    // Issues one request, then scrambles the inputs; lat = cycles from acceptance edge to ACK.
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] nb, output int l);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = wr; bus.i_addr = a; bus.i_wdata = d; bus.i_num_byte = nb;
        @(posedge clk);
        @(negedge clk);
        bus.i_req = 1'b0; bus.i_addr = 32'hFFFF_FFFF; bus.i_wdata = 32'h5555_5555; bus.i_num_byte = 3'd7;
        l = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.o_ACK) begin l = c; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (bus.o_ACK !== 1'b0) $display("FAIL rst_ack: got %b want 0", bus.o_ACK); else pass_cnt++;
        total_cnt++; if (bus.o_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", bus.o_rdata); else pass_cnt++;
        total_cnt++;
        if ({bus.o_SRAM_CE_N, bus.o_SRAM_OE_N, bus.o_SRAM_WE_N, bus.o_SRAM_UB_N, bus.o_SRAM_LB_N, bus.o_SRAM_DQ_oe} !== 6'b111110)
            $display("FAIL rst_strobes: got %b want 111110",
                     {bus.o_SRAM_CE_N, bus.o_SRAM_OE_N, bus.o_SRAM_WE_N, bus.o_SRAM_UB_N, bus.o_SRAM_LB_N, bus.o_SRAM_DQ_oe});
        else pass_cnt++;
        total_cnt++; if (bus.o_SRAM_ADDR !== 18'h0) $display("FAIL rst_addr: got %h want 0", bus.o_SRAM_ADDR); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_word();
        snap();
        do_access(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd4, lat);
        total_cnt++; if (lat !== 5) $display("FAIL sw_latency: got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if (we_cnt - w0 !== 2) $display("FAIL sw_we_cycles: got %0d want 2", we_cnt - w0); else pass_cnt++;
        total_cnt++; if (ce_cnt - c0 !== 4) $display("FAIL sw_ce_cycles: got %0d want 4", ce_cnt - c0); else pass_cnt++;
        total_cnt++; if (mem[8'h08] !== 16'hBEEF) $display("FAIL sw_mem_lo: got %h want beef", mem[8'h08]); else pass_cnt++;
        total_cnt++; if (mem[8'h09] !== 16'hDEAD) $display("FAIL sw_mem_hi: got %h want dead", mem[8'h09]); else pass_cnt++;
        snap();
        do_access(1'b0, 32'h10, 32'h0, 3'd4, lat);
        total_cnt++; if (lat !== 5) $display("FAIL lw_latency: got %0d want 5", lat); else pass_cnt++;
        total_cnt++; if (bus.o_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_rdata: got %h want deadbeef", bus.o_rdata); else pass_cnt++;
        total_cnt++; if (oe_cnt - o0 !== 4) $display("FAIL lw_oe_cycles: got %0d want 4", oe_cnt - o0); else pass_cnt++;
        total_cnt++; if (bus.o_err !== 1'b0) $display("FAIL lw_err: got %b want 0", bus.o_err); else pass_cnt++;
    endtask

    task automatic test_byte_half();
        do_access(1'b1, 32'h10, 32'h0000_80F0, 3'd2, lat);
        total_cnt++; if (lat !== 3) $display("FAIL sh_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (bus.o_rdata !== 32'hDEAD_BEEF) $display("FAIL store_keeps_rdata: got %h want deadbeef", bus.o_rdata); else pass_cnt++;
        snap();
        do_access(1'b0, 32'h11, 32'h0, 3'd0, lat);
        total_cnt++; if (lat !== 3) $display("FAIL lb_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (bus.o_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata: got %h want ffffff80", bus.o_rdata); else pass_cnt++;
        total_cnt++; if ((ub_cnt - u0 !== 2) || (lb_cnt - l0 !== 0))
            $display("FAIL lb_lanes: got ub=%0d lb=%0d want ub=2 lb=0", ub_cnt - u0, lb_cnt - l0); else pass_cnt++;
        do_access(1'b0, 32'h10, 32'h0, 3'd1, lat);
        total_cnt++; if (lat !== 3) $display("FAIL lbu_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (bus.o_rdata !== 32'h0000_00F0) $display("FAIL lbu_rdata: got %h want 000000f0", bus.o_rdata); else pass_cnt++;
        do_access(1'b1, 32'h10, 32'h0000_8001, 3'd2, lat);
        do_access(1'b0, 32'h10, 32'h0, 3'd2, lat);
        total_cnt++; if (bus.o_rdata !== 32'hFFFF_8001) $display("FAIL lh_rdata: got %h want ffff8001", bus.o_rdata); else pass_cnt++;
        do_access(1'b0, 32'h10, 32'h0, 3'd3, lat);
        total_cnt++; if (bus.o_rdata !== 32'h0000_8001) $display("FAIL lhu_rdata: got %h want 00008001", bus.o_rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = 1'b1; bus.i_addr = 32'h40; bus.i_wdata = 32'h1111_2222; bus.i_num_byte = 3'd4;
        @(posedge clk);
        @(negedge clk); bus.i_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({bus.o_SRAM_CE_N, bus.o_SRAM_OE_N, bus.o_SRAM_WE_N, bus.o_SRAM_UB_N, bus.o_SRAM_LB_N, bus.o_SRAM_DQ_oe, bus.o_ACK} !== 7'b1111100)
            $display("FAIL midrst_strobes: got %b want 1111100",
                     {bus.o_SRAM_CE_N, bus.o_SRAM_OE_N, bus.o_SRAM_WE_N, bus.o_SRAM_UB_N, bus.o_SRAM_LB_N, bus.o_SRAM_DQ_oe, bus.o_ACK});
        else pass_cnt++;
        total_cnt++; if (bus.o_rdata !== 32'h0) $display("FAIL midrst_rdata: got %h want 0", bus.o_rdata); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        snap();
        repeat (8) @(posedge clk);
        total_cnt++; if (ce_cnt - c0 !== 0) $display("FAIL midrst_idle: got %0d ce cycles want 0", ce_cnt - c0); else pass_cnt++;
        do_access(1'b1, 32'h20, 32'h0000_1234, 3'd2, lat);
        snap();
        do_access(1'b1, 32'h21, 32'h0000_00A5, 3'd0, lat);
        total_cnt++; if (lat !== 3) $display("FAIL sb_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (mem[8'h10] !== 16'hA534) $display("FAIL sb_mem: got %h want a534", mem[8'h10]); else pass_cnt++;
        total_cnt++; if ((ub_cnt - u0 !== 2) || (lb_cnt - l0 !== 0))
            $display("FAIL sb_lanes: got ub=%0d lb=%0d want ub=2 lb=0", ub_cnt - u0, lb_cnt - l0); else pass_cnt++;
        do_access(1'b0, 32'h10, 32'h0, 3'd4, lat);
        total_cnt++; if (bus.o_rdata !== 32'hDEAD_8001) $display("FAIL lw2_rdata: got %h want dead8001", bus.o_rdata); else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] ea [3];
        logic [2:0]  en [3];
        ea = '{32'h13, 32'h12, 32'h10};
        en = '{3'd2, 3'd4, 3'd6};
        for (int i = 0; i < 3; i++) begin
            snap();
            do_access(1'b0, ea[i], 32'h0, en[i], lat);
            total_cnt++; if (lat !== 1) $display("FAIL err%0d_latency: got %0d want 1", i, lat); else pass_cnt++;
            total_cnt++; if (bus.o_err !== 1'b1) $display("FAIL err%0d_flag: got %b want 1", i, bus.o_err); else pass_cnt++;
            total_cnt++; if (bus.o_rdata !== 32'h0) $display("FAIL err%0d_rdata: got %h want 0", i, bus.o_rdata); else pass_cnt++;
            total_cnt++; if (ce_cnt - c0 !== 0) $display("FAIL err%0d_ce: got %0d want 0", i, ce_cnt - c0); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int acks, a1, a2;
        acks = 0; a1 = -1; a2 = -1;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = 1'b0; bus.i_addr = 32'h10; bus.i_num_byte = 3'd3;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (bus.o_ACK) begin
                acks++;
                if (acks == 1) a1 = c;
                if (acks == 2) begin a2 = c; bus.i_req = 1'b0; end
            end
        end
        bus.i_req = 1'b0;
        total_cnt++; if (a1 !== 3) $display("FAIL b2b_ack1: got %0d want 3", a1); else pass_cnt++;
        total_cnt++; if (a2 !== 7) $display("FAIL b2b_ack2: got %0d want 7", a2); else pass_cnt++;
        total_cnt++; if (acks !== 2) $display("FAIL b2b_count: got %0d want 2", acks); else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_req = 1'b0; bus.i_wren = 1'b0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_num_byte = '0;
        test_reset();
        test_word();
        test_byte_half();
        test_reset_mid_op();
        test_errors();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/lsu_sram_resp.md
Name: lsu_sram_resp

Overview:
- Memory-side responder to the core's load/store requests (mem_wren, num_byte, address, store data).
- Performs multi-cycle accesses to an external 16-bit asynchronous SRAM and returns sign/zero-extended load data.
- Returns a one-cycle o_ACK, which the core uses to release its PC stall.
- Sits between the LSU address decode (in_sram region) and the board SRAM pins.

Parameters:
- WAIT_CYC, 2: cycles each SRAM half-word phase is held; legal range 2..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_req  in  1  access request; sampled only in IDLE.
- i_wren  in  1  1 = store, 0 = load.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- i_num_byte  in  3  0 = lb/sb, 1 = lbu, 2 = lh/sh, 3 = lhu, 4 = lw/sw; 5..7 illegal.
- o_rdata  out  32  extended load data; valid with o_ACK and held until the next ACK.
- o_ACK  out  1  one-cycle completion pulse.
- o_err  out  1  pulses with o_ACK on a misaligned or illegal request.
- o_SRAM_ADDR  out  SRAM_AW  half-word address.
- o_SRAM_DQ  out  16  write data.
- i_SRAM_DQ  in  16  read data.
- o_SRAM_DQ_oe  out  1  pad output enable.
- o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N  out  1 each  active-low strobes.

Behaviour:
- Registered outputs.
  - Reset values: o_rdata = 0, o_ACK = 0, o_err = 0, o_SRAM_ADDR = 0, o_SRAM_DQ = 0, o_SRAM_DQ_oe = 0.
  - All _N strobes = 1.
  - State = IDLE.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE
  - When i_req = 1 at edge T: latch i_wren, i_addr, i_wdata, i_num_byte.
  - Clear the phase counter.
  - Select the next state:
    - Illegal i_num_byte (5..7), half-word access with addr[0] = 1, or word access with addr[1:0] != 0 → DONE, o_err = 1, no SRAM strobes, o_rdata forced to 0.
    - Load → RD_LO.
    - Store → WR_LO.
- Address mapping: o_SRAM_ADDR = addr[SRAM_AW:1] in the LO phase; +1 in the HI phase (word only, wraps modulo 2^SRAM_AW).
- Byte lanes
  - Byte access: addr[0] = 0 → LB_N = 0 (DQ[7:0]); addr[0] = 1 → UB_N = 0 (DQ[15:8]).
  - Half-word and word accesses: both lanes enabled.
- Each phase lasts exactly WAIT_CYC cycles. CE_N = 0, address, and lanes are stable for the whole phase.
- Read phase
  - OE_N = 0, DQ_oe = 0.
  - i_SRAM_DQ is captured on the last phase cycle.
  - RD_LO → RD_HI if word, else → DONE. RD_HI → DONE.
- Write phase
  - OE_N = 1, DQ_oe = 1.
  - o_SRAM_DQ = wdata[15:0] in LO and wdata[31:16] in HI. For sb, the byte is replicated on both lanes.
  - WE_N = 0 on all phase cycles except the last, giving a data/address hold cycle.
  - WR_LO → WR_HI if word, else → DONE.
- DONE
  - o_ACK = 1 for exactly one cycle; all strobes deasserted.
  - Returns to IDLE next cycle. i_req is re-sampled only from IDLE, so at most one ACK per request; the requester must change or drop i_req after the ACK.
- Latency (ACK cycle after acceptance edge T):
  - Byte/half: T + WAIT_CYC + 1.
  - Word: T + 2·WAIT_CYC + 1.
  - Error: T + 1.
- Load extension
  - lb: sign-extend the selected byte.
  - lbu: zero-extend the selected byte.
  - lh: sign-extend 16 bits.
  - lhu: zero-extend 16 bits.
  - lw: {HI, LO}.
- Stores leave o_rdata unchanged.
- Inputs are ignored outside IDLE; i_addr/i_wdata changes mid-access have no effect.
- Reset mid-operation: at the next edge all strobes return to 1, DQ_oe = 0, state = IDLE, no ACK is generated, and o_rdata = 0.

Test Plan:
- sw addr 0x0000_0010, data 0xDEAD_BEEF, WAIT_CYC = 2:
  - SRAM[0x8] = 0xBEEF, SRAM[0x9] = 0xDEAD.
  - WE_N low for 1 cycle per phase.
  - ACK at T+5.
- lw of the same address:
  - o_rdata = 0xDEAD_BEEF at ACK, T+5.
  - OE_N low for 4 cycles.
- With SRAM[0x8] = 0x80F0:
  - lb at 0x11 → 0xFFFF_FF80, UB_N = 0, LB_N = 1.
  - lbu at 0x10 → 0x0000_00F0.
  - Each ACK at T+3.
- With SRAM[0x8] = 0x8001:
  - lh at 0x10 → 0xFFFF_8001.
  - lhu at 0x10 → 0x0000_8001.
- Error cases, each giving ACK + o_err at T+1, no CE_N activity, o_rdata = 0:
  - lh at 0x13.
  - lw at 0x12.
  - i_num_byte = 6.
- Reset and request handling:
  - i_rst asserted 2 cycles into an sw: strobes inactive next edge, no ACK, IDLE.
  - A subsequent sb 0xA5 at 0x21 writes only UB (SRAM[0x10][15:8] = 0xA5), ACK at T+3.
  - i_req held high across ACK → second access starts only after the IDLE cycle.
